// File: rtl/bsg_manycore_pkg.sv
// Shared types for the print-stat tag logger: log entry layout and its width helper.
package bsg_manycore_pkg;

  localparam int unsigned print_stat_tag_width_gp = 32;
  localparam int unsigned print_stat_ctr_width_gp = 64;

  // Default-width entry; the counter occupies the MSBs.
  typedef struct packed {
    logic [print_stat_ctr_width_gp-1:0] ctr;
    logic [print_stat_tag_width_gp-1:0] tag;
  } bsg_print_stat_log_entry_s;

  function automatic int unsigned bsg_print_stat_log_entry_width(
    input int unsigned ctr_width,
    input int unsigned data_width
  );
    return ctr_width + data_width;
  endfunction

endpackage

// File: rtl/bsg_mem_1r1w.sv
// Simple 1-write/1-read register-file storage with asynchronous read; contents are not reset.
module bsg_mem_1r1w #(
  parameter int unsigned width_p = 96,
  parameter int unsigned els_p   = 16
) (
  input  logic                     clk_i,
  input  logic                     w_v_i,
  input  logic [$clog2(els_p)-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [$clog2(els_p)-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) mem[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bsg_print_stat_tag_logger.sv
// Captures timestamped print-stat tags into a small FIFO for a downstream consumer,
// counting events lost while the buffer is full.
module bsg_print_stat_tag_logger
  import bsg_manycore_pkg::*;
#(
  parameter int unsigned data_width_p = 32,
  parameter int unsigned ctr_width_p  = 64,
  parameter int unsigned els_p        = 16,
  parameter int unsigned drop_width_p = 16
) (
  input  logic                                      clk_i,
  input  logic                                      reset_n_i,
  input  logic                                      en_i,
  input  logic                                      print_stat_v_i,
  input  logic [data_width_p-1:0]                   print_stat_tag_i,
  input  logic [ctr_width_p-1:0]                    global_ctr_i,
  output logic                                      v_o,
  output logic [ctr_width_p+data_width_p-1:0]       data_o,
  input  logic                                      yumi_i,
  output logic [$clog2(els_p+1)-1:0]                count_o,
  output logic [drop_width_p-1:0]                   dropped_o,
  output logic                                      overflow_o,
  input  logic                                      clear_i
);

  localparam int unsigned addr_w_lp  = $clog2(els_p);
  localparam int unsigned count_w_lp = $clog2(els_p + 1);
  localparam int unsigned entry_w_lp = bsg_print_stat_log_entry_width(ctr_width_p, data_width_p);

  logic [addr_w_lp-1:0]    wptr_r, wptr_n, rptr_r, rptr_n, occ;
  logic                    full_r, full_n, v_r, v_n;
  logic [drop_width_p-1:0] dropped_r, dropped_n;
  logic                    overflow_r, overflow_n;
  logic                    deq, cap, enq, drop;

  // Next-state for pointers, full/valid flags and drop bookkeeping.
  always_comb begin
    deq        = yumi_i & v_r;
    cap        = print_stat_v_i & en_i;
    enq        = cap & (~full_r | deq);
    drop       = cap & full_r & ~deq;
    wptr_n     = wptr_r;
    rptr_n     = rptr_r;
    full_n     = full_r;
    v_n        = v_r;
    dropped_n  = dropped_r;
    overflow_n = overflow_r;

    if (enq) wptr_n = addr_w_lp'(wptr_r + addr_w_lp'(1));
    if (deq) rptr_n = addr_w_lp'(rptr_r + addr_w_lp'(1));

    if (enq && !deq) begin
      v_n    = 1'b1;
      full_n = (wptr_n == rptr_r);
    end else if (deq && !enq) begin
      full_n = 1'b0;
      v_n    = (rptr_n != wptr_r);
    end

    // Clear wins over a drop in the same cycle.
    if (clear_i) begin
      dropped_n  = '0;
      overflow_n = 1'b0;
    end else if (drop) begin
      overflow_n = 1'b1;
      if (!(&dropped_r)) dropped_n = drop_width_p'(dropped_r + drop_width_p'(1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wptr_r     <= '0;
      rptr_r     <= '0;
      full_r     <= 1'b0;
      v_r        <= 1'b0;
      dropped_r  <= '0;
      overflow_r <= 1'b0;
    end else begin
      wptr_r     <= wptr_n;
      rptr_r     <= rptr_n;
      full_r     <= full_n;
      v_r        <= v_n;
      dropped_r  <= dropped_n;
      overflow_r <= overflow_n;
    end
  end

  bsg_mem_1r1w #(
    .width_p(entry_w_lp),
    .els_p  (els_p)
  ) mem (
    .clk_i   (clk_i),
    .w_v_i   (enq & reset_n_i),
    .w_addr_i(wptr_r),
    .w_data_i({global_ctr_i, print_stat_tag_i}),
    .r_addr_i(rptr_r),
    .r_data_o(data_o)
  );

  // Full/empty bit disambiguates equal pointers.
  assign occ        = addr_w_lp'(wptr_r - rptr_r);
  assign count_o    = full_r ? count_w_lp'(els_p) : count_w_lp'(occ);
  assign v_o        = v_r;
  assign dropped_o  = dropped_r;
  assign overflow_o = overflow_r;

  yumi_without_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_r);

endmodule

// File: tb/tb_bsg_print_stat_tag_logger.sv
// Directed self-checking bench for bsg_print_stat_tag_logger (default instance plus a
// small-counter instance for saturation and clear priority).
module tb_bsg_print_stat_tag_logger;
  import bsg_manycore_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        ev = 1'b0;
  logic [31:0] tag = '0;
  logic [63:0] gctr = '0;
  logic        yumi = 1'b0;
  logic        clear = 1'b0;
  logic        a_v, a_ovf;
  logic [95:0] a_data;
  logic [4:0]  a_count;
  logic [15:0] a_drop;

  logic        b_ev = 1'b0;
  logic        b_yumi = 1'b0;
  logic        b_clear = 1'b0;
  logic        b_v, b_ovf;
  logic [95:0] b_data;
  logic [2:0]  b_count;
  logic [1:0]  b_drop;

  int checks = 0;
  int errors = 0;
  bsg_print_stat_log_entry_s exp_q[$];
  bsg_print_stat_log_entry_s e;

  always #5 clk = ~clk;

  bsg_print_stat_tag_logger dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .print_stat_v_i(ev),
    .print_stat_tag_i(tag), .global_ctr_i(gctr), .v_o(a_v), .data_o(a_data),
    .yumi_i(yumi), .count_o(a_count), .dropped_o(a_drop), .overflow_o(a_ovf),
    .clear_i(clear)
  );

  bsg_print_stat_tag_logger #(.els_p(4), .drop_width_p(2)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .print_stat_v_i(b_ev),
    .print_stat_tag_i(tag), .global_ctr_i(gctr), .v_o(b_v), .data_o(b_data),
    .yumi_i(b_yumi), .count_o(b_count), .dropped_o(b_drop), .overflow_o(b_ovf),
    .clear_i(b_clear)
  );

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bsg_print_stat_log_entry_s mk(input logic [63:0] c, input logic [31:0] t);
    bsg_print_stat_log_entry_s r;
    r.ctr = c;
    r.tag = t;
    return r;
  endfunction

  // One-cycle capture on dut_a, recorded in the scoreboard.
  task automatic push(input logic [63:0] c, input logic [31:0] t);
    ev = 1'b1; gctr = c; tag = t;
    tick();
    ev = 1'b0;
    exp_q.push_back(mk(c, t));
  endtask

  task automatic pop_check(input string name);
    e = exp_q.pop_front();
    check(name, a_data, e);
    yumi = 1'b1;
    tick();
    yumi = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    check("rst_count", a_count, 0);
    check("rst_v", a_v, 0);
    check("rst_drop", a_drop, 0);
    check("rst_ovf", a_ovf, 0);

    // Single capture, one-cycle latency.
    rst_n = 1'b1; en = 1'b1;
    ev = 1'b1; gctr = 64'd100; tag = 32'h0000_0A01;
    tick();
    ev = 1'b0;
    check("first_v", a_v, 1);
    check("first_data", a_data, {64'd100, 32'h0000_0A01});
    check("first_count", a_count, 1);
    yumi = 1'b1; tick(); yumi = 1'b0;
    check("drain_v", a_v, 0);
    check("drain_count", a_count, 0);

    // Fill to 16, then one overflow.
    for (int i = 0; i < 16; i++) push(64'(1000 + i), 32'(32'h100 + i));
    check("full_count", a_count, 16);
    check("full_ovf", a_ovf, 0);
    ev = 1'b1; gctr = 64'd2000; tag = 32'hDEAD;
    tick();
    ev = 1'b0;
    check("ovf_count", a_count, 16);
    check("ovf_flag", a_ovf, 1);
    check("ovf_drop", a_drop, 1);
    check("ovf_head", a_data, mk(64'd1000, 32'h100));
    tick();
    check("hold_head", a_data, mk(64'd1000, 32'h100));

    // Capture concurrent with yumi while full.
    ev = 1'b1; yumi = 1'b1; gctr = 64'd5000; tag = 32'hBEEF;
    tick();
    ev = 1'b0; yumi = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(mk(64'd5000, 32'hBEEF));
    check("fullyumi_count", a_count, 16);
    check("fullyumi_drop", a_drop, 1);
    for (int i = 0; i < 16; i++) pop_check("full_drain");
    check("full_drain_v", a_v, 0);

    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_drop", a_drop, 0);
    check("clear_ovf", a_ovf, 0);

    // Disabled capture is ignored without counting.
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ev = 1'b1; tag = 32'(i); tick();
    end
    ev = 1'b0;
    check("dis_v", a_v, 0);
    check("dis_drop", a_drop, 0);
    check("dis_count", a_count, 0);
    en = 1'b1;

    // Simultaneous capture and yumi on a non-empty buffer.
    push(64'd300, 32'h200);
    push(64'd301, 32'h201);
    ev = 1'b1; yumi = 1'b1; gctr = 64'd302; tag = 32'h202;
    tick();
    ev = 1'b0; yumi = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(mk(64'd302, 32'h202));
    check("simul_count", a_count, 2);
    check("simul_head", a_data, mk(64'd301, 32'h201));
    for (int i = 0; i < 5; i++) push(64'(303 + i), 32'(32'h203 + i));
    check("pre_rst_count", a_count, 7);

    // Mid-operation reset with a capture in the reset cycle.
    rst_n = 1'b0; ev = 1'b1; tag = 32'hBAD;
    tick();
    rst_n = 1'b1; ev = 1'b0;
    exp_q.delete();
    check("mid_rst_count", a_count, 0);
    check("mid_rst_v", a_v, 0);

    // 20 entries through the wrap.
    for (int i = 0; i < 10; i++) push(64'(7000 + i), 32'(32'h300 + i));
    for (int i = 0; i < 5; i++) pop_check("wrap_a");
    for (int i = 10; i < 20; i++) push(64'(7000 + i), 32'(32'h300 + i));
    check("wrap_count", a_count, 15);
    for (int i = 0; i < 15; i++) pop_check("wrap_b");
    check("wrap_v", a_v, 0);
    check("wrap_drop", a_drop, 0);

    // Small drop counter saturates; clear beats a concurrent drop.
    b_ev = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tag = 32'(i); tick();
    end
    check("b_full", b_count, 4);
    check("b_nodrop", b_drop, 0);
    for (int i = 0; i < 5; i++) tick();
    check("b_sat", b_drop, 3);
    check("b_ovf", b_ovf, 1);
    check("b_head", b_data[31:0], 0);
    b_clear = 1'b1;
    tick();
    b_clear = 1'b0; b_ev = 1'b0;
    check("b_clear_drop", b_drop, 0);
    check("b_clear_ovf", b_ovf, 0);
    check("b_clear_count", b_count, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
